// File: rtl/compare_serial.sv
// compare_serial: bit-serial magnitude comparator, MSB first, one bit per clock.
// Latency: done pulses in the cycle after the n-th RUN edge. n is the 1-based position of
//   the first differing bit from the MSB, or WIDTH when the operands are equal or EARLY_EXIT=0.
// Backpressure: none. start is sampled only in IDLE and is ignored while RUN or DONE.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        job request, accepted only in IDLE
//   a, b         WIDTH-bit operands, latched on an accepted start
//   signed_mode  two's-complement compare (present only when COMPARE_SIGNED_EN is defined)
//   busy         high while the scan is running
//   done         one-cycle pulse when gt/lt/eq hold a new result
//   gt, lt, eq   registered result flags, held until the next accepted start
//
// Optional feature macro: COMPARE_SIGNED_EN (adds signed_mode and two's-complement compare).
module compare_serial #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef COMPARE_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]   idx_q;
  logic            busy_q;
  logic            done_q;
  logic            gt_q;
  logic            lt_q;
  logic            eq_q;
`ifdef COMPARE_SIGNED_EN
  logic            sgn_q;
`endif

  logic bit_a;
  logic bit_b;
  logic differ;
  logic invert;
  logic found;
  logic cmp_gt;
  logic cmp_lt;

  always_comb begin
    bit_a  = a_q[idx_q];
    bit_b  = b_q[idx_q];
    differ = bit_a ^ bit_b;
`ifdef COMPARE_SIGNED_EN
    // A differing sign bit decides a signed compare the opposite way: the 1 is negative.
    invert = sgn_q && (idx_q == IDX_MSB);
`else
    invert = 1'b0;
`endif
    cmp_gt = invert ? (~bit_a & bit_b) : (bit_a & ~bit_b);
    cmp_lt = invert ? (bit_a & ~bit_b) : (~bit_a & bit_b);
    // In full-scan mode gt/lt are set at the first difference, so they double as the
    // "difference already seen" flag.
    found  = gt_q | lt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
`ifdef COMPARE_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
`ifdef COMPARE_SIGNED_EN
            sgn_q   <= signed_mode;
`endif
            idx_q   <= IDX_MSB;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          if (differ && (EARLY_EXIT != 0)) begin
            gt_q    <= cmp_gt;
            lt_q    <= cmp_lt;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            if (differ && !found) begin
              gt_q <= cmp_gt;
              lt_q <= cmp_lt;
            end
            if (idx_q == '0) begin
              eq_q    <= !found && !differ;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q <= idx_q - IW'(1);
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign lt   = lt_q;
  assign eq   = eq_q;

endmodule

// File: tb/tb_compare_serial.sv
// Testbench for compare_serial: an 8-bit early-exit instance and a 16-bit full-scan instance
// run the same job stream. Expected flags and done times are queued at issue and checked
// by per-instance monitors whenever done is seen.
module tb_compare_serial;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s8, s16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, gt8, lt8, eq8;
  logic        busy16, done16, gt16, lt16, eq16;
`ifdef COMPARE_SIGNED_EN
  logic        sm8, sm16;
`endif

  compare_serial #(.WIDTH(8), .EARLY_EXIT(1)) u_ee8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
`ifdef COMPARE_SIGNED_EN
    .signed_mode(sm8),
`endif
    .busy(busy8), .done(done8), .gt(gt8), .lt(lt8), .eq(eq8)
  );

  compare_serial #(.WIDTH(16), .EARLY_EXIT(0)) u_full16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16),
`ifdef COMPARE_SIGNED_EN
    .signed_mode(sm16),
`endif
    .busy(busy16), .done(done16), .gt(gt16), .lt(lt16), .eq(eq16)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] flags;  // {gt, lt, eq}
    int         due;    // cycle count at which done must be seen
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  logic [2:0] last8, last16;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: compare the operands as integers; latency is the position of the
  // first differing bit from the MSB, or the full width.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input int w,
                                 input bit ee, input bit sgn, input int c0);
    exp_t   e;
    longint sa, sb;
    int     n;
    bit     hit;
    sa = longint'(av);
    sb = longint'(bv);
    if (sgn && av[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && bv[w-1]) sb = sb - (longint'(1) << w);
    e.flags = {sa > sb, sa < sb, sa == sb};
    n   = w;
    hit = 1'b0;
    if (ee) begin
      for (int i = w - 1; i >= 0; i--) begin
        if (!hit && (av[i] != bv[i])) begin
          n   = w - i;
          hit = 1'b1;
        end
      end
    end
    e.due = c0 + n;
    return e;
  endfunction

  // Monitors
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        chk("dut8 unexpected done", 32'(done8), 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("dut8 flags", 32'({gt8, lt8, eq8}), 32'(e.flags));
        chk("dut8 latency", 32'(cyc), 32'(e.due));
        chk("dut8 busy at done", 32'(busy8), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done16) begin
      if (q16.size() == 0) begin
        chk("dut16 unexpected done", 32'(done16), 32'd0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("dut16 flags", 32'({gt16, lt16, eq16}), 32'(e.flags));
        chk("dut16 latency", 32'(cyc), 32'(e.due));
        chk("dut16 busy at done", 32'(busy16), 32'd0);
      end
    end
  end

  task automatic issue(input logic [7:0] av8, input logic [7:0] bv8,
                       input logic [15:0] av16, input logic [15:0] bv16, input bit sgn);
    int   c0;
    exp_t e8, e16;
    bit   s;
`ifdef COMPARE_SIGNED_EN
    s = sgn;
`else
    s = 1'b0;
`endif
    @(negedge clk);
    a8 = av8; b8 = bv8; a16 = av16; b16 = bv16;
`ifdef COMPARE_SIGNED_EN
    sm8 = s; sm16 = s;
`endif
    s8 = 1'b1; s16 = 1'b1;
    @(posedge clk);
    #1;
    s8 = 1'b0; s16 = 1'b0;
    c0  = cyc;
    e8  = model({8'h00, av8}, {8'h00, bv8}, 8, 1'b1, s, c0);
    e16 = model(av16, bv16, 16, 1'b0, s, c0);
    q8.push_back(e8);
    q16.push_back(e16);
    last8  = e8.flags;
    last16 = e16.flags;
    chk("dut8 busy after start", 32'(busy8), 32'd1);
    chk("dut16 busy after start", 32'(busy16), 32'd1);
    chk("dut8 flags cleared", 32'({gt8, lt8, eq8}), 32'd0);
    // Only the latched copies may matter from here on.
    a8 = 8'($urandom); b8 = 8'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("jobs outstanding after wait", 32'(q8.size() + q16.size()), 32'd0);
    @(negedge clk);
    #1;
    chk("dut8 result held", 32'({gt8, lt8, eq8}), 32'(last8));
    chk("dut16 result held", 32'({gt16, lt16, eq16}), 32'(last16));
  endtask

  initial begin
    int spurious;
    rst_n = 1'b0;
    s8 = 1'b0; s16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
`ifdef COMPARE_SIGNED_EN
    sm8 = 1'b0; sm16 = 1'b0;
`endif
    #1;
    chk("reset dut8 outputs", 32'({busy8, done8, gt8, lt8, eq8}), 32'd0);
    chk("reset dut16 outputs", 32'({busy16, done16, gt16, lt16, eq16}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    issue(8'd100, 8'd30, 16'h0001, 16'h0000, 1'b0);   wait_idle();
    issue(8'h5A, 8'h5A, 16'h8000, 16'h0000, 1'b0);    wait_idle();
    issue(8'h80, 8'h00, 16'h1234, 16'h1234, 1'b0);    wait_idle();
    issue(8'h00, 8'hFF, 16'hFFFF, 16'hFFFE, 1'b0);    wait_idle();
    issue(8'h80, 8'h01, 16'h8000, 16'h0001, 1'b1);    wait_idle();
    issue(8'h80, 8'h01, 16'h8000, 16'h0001, 1'b0);    wait_idle();

    // Start during RUN must be ignored
    issue(8'd3, 8'd5, 16'd3, 16'd5, 1'b0);
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd1; a16 = 16'd9; b16 = 16'd1;
    s8 = 1'b1; s16 = 1'b1;
    @(negedge clk);
    s8 = 1'b0; s16 = 1'b0;
    wait_idle();

    // Randomized jobs
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  ra8, rb8;
      logic [15:0] ra16, rb16;
      ra8  = 8'($urandom);
      rb8  = ($urandom_range(0, 3) == 0) ? ra8 : 8'($urandom);
      ra16 = 16'($urandom);
      rb16 = ($urandom_range(0, 3) == 0) ? ra16 : (ra16 ^ 16'(1 << $urandom_range(0, 15)));
      issue(ra8, rb8, ra16, rb16, 1'($urandom));
      wait_idle();
    end

    // Reset in the middle of a scan
    issue(8'd1, 8'd2, 16'd1, 16'd2, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-run reset dut8", 32'({busy8, done8, gt8, lt8, eq8}), 32'd0);
    chk("mid-run reset dut16", 32'({busy16, done16, gt16, lt16, eq16}), 32'd0);
    q8.delete();
    q16.delete();
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (24) begin
      @(negedge clk);
      if (done8 || done16) spurious++;
    end
    chk("no done after reset release", 32'(spurious), 32'd0);

    // Post-reset job still works
    issue(8'd7, 8'd200, 16'hABCD, 16'hABCC, 1'b0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got %0d checks, expected run to finish", checks);
    $fatal(1, "timeout");
  end

endmodule
